// File: rtl/uart_pkg.sv
// Shared definitions for the UART datapath (transmitter now, receiver later).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } uart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clocks while enabled and flags the last
// cycle of each bit period with a one-cycle bit_done.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, idle holds at zero, wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CNT_ZERO;
    end else if (!en) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_axis.sv
// AXI-Stream byte sink driving an asynchronous UART frame on tx, with an
// optional idle gap after bytes marked with s_tlast.
module uart_tx_axis
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_BITS     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic                  tx,
  output logic                  busy
);

  if (!(PARITY == PAR_NONE || PARITY == PAR_EVEN || PARITY == PAR_ODD) ||
      !(STOP_BITS == 1 || STOP_BITS == 2) || (CLKS_PER_BIT < 2)) begin : g_param_check
    $error("uart_tx_axis: illegal PARITY, STOP_BITS or CLKS_PER_BIT");
  end

  localparam int MAX_SG = (STOP_BITS > GAP_BITS) ? STOP_BITS : GAP_BITS;
  localparam int MAXB   = (DATA_WIDTH > MAX_SG) ? DATA_WIDTH : MAX_SG;
  localparam int BW     = $clog2(MAXB + 1);

  localparam logic [BW-1:0] BIT_ZERO      = BW'(0);
  localparam logic [BW-1:0] BIT_ONE       = BW'(1);
  localparam logic [BW-1:0] DATA_LAST     = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST     = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] GAP_LAST      = BW'(GAP_BITS - 1);

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d);
    logic p;
    p = ^d;
    if (PARITY == PAR_ODD) begin
      p = ~p;
    end else begin
      p = p;
    end
    return p;
  endfunction

  uart_tx_state_t        state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  last_q, last_d;
  logic                  tx_q, tx_d;
  logic                  tready_q;
  logic                  busy_q;
  logic                  bit_done;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q != ST_IDLE),
    .clear   (state_d != state_q),
    .bit_done(bit_done)
  );

  // Next-state logic, byte capture and bit sequencing.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    last_d    = last_q;
    case (state_q)
      ST_IDLE: begin
        if (s_tvalid && tready_q) begin
          shift_d = s_tdata;
          par_d   = calc_parity(s_tdata);
          last_d  = s_tlast;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (!bit_done) begin
          state_d = ST_DATA;
        end else if (bit_cnt_q == DATA_LAST) begin
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
          shift_d   = shift_q >> 1;
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (!bit_done) begin
          state_d = ST_STOP;
        end else if (bit_cnt_q == STOP_LAST) begin
          state_d = (last_q && (GAP_BITS > 0)) ? ST_GAP : ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      ST_GAP: begin
        if (!bit_done) begin
          state_d = ST_GAP;
        end else if (bit_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (state_d != state_q) begin
      bit_cnt_d = BIT_ZERO;
    end else begin
      bit_cnt_d = bit_cnt_d;
    end
  end

  // Line level decoded from the next state so tx registers in step with the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= BIT_ZERO;
      shift_q   <= {DATA_WIDTH{1'b0}};
      par_q     <= 1'b0;
      last_q    <= 1'b0;
      tx_q      <= 1'b1;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      last_q    <= last_d;
      tx_q      <= tx_d;
      tready_q  <= (state_d == ST_IDLE);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign s_tready = tready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule

// File: doc/uart_tx_axis.md
# uart_tx_axis

AXI-Stream-to-UART transmitter: accepts bytes on an AXIS slave port and serializes each as a standard asynchronous UART frame on `tx`. It is the stage directly downstream of the AXIS source in the UART datapath, consuming what the stream producer sends and driving the serial line. Frame boundaries (`s_tlast`) optionally insert an idle gap on the line after the last byte of a frame.

## Interface

- `DATA_WIDTH`, 8: payload bits per UART character, sent LSB first.
- `CLKS_PER_BIT`, 16: clock cycles per bit period; must be ≥ 2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `GAP_BITS`, 0: idle (mark) bit periods inserted after a byte accepted with `s_tlast`=1; 0 disables the gap.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_tdata` in DATA_WIDTH: byte to transmit.
- `s_tvalid` in 1: source has data.
- `s_tready` out 1: block accepts data this cycle.
- `s_tlast` in 1: last byte of an AXIS frame.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high in every state except IDLE.

## Operation

- States: IDLE, START, DATA, PARITY, STOP, GAP.
- IDLE: `tx`=1, `s_tready`=1. Transfer occurs on a clock edge with `s_tvalid && s_tready`. At that edge, `s_tdata` and `s_tlast` are latched, the parity bit is computed, and the FSM goes to START.
- START: `tx`=0 for one bit period, then DATA.
- DATA: bit index 0..DATA_WIDTH-1, LSB first, each bit held for one bit period. After the last bit, go to PARITY if `PARITY`≠0, otherwise STOP.
- Parity: even = XOR-reduce of the data; odd = inverted XOR-reduce.
- PARITY: parity bit for one bit period, then STOP.
- STOP: `tx`=1 for STOP_BITS bit periods. Then go to GAP if the latched `tlast` is set and GAP_BITS>0, otherwise IDLE.
- GAP: `tx`=1 for GAP_BITS bit periods, then IDLE.
- `s_tready` is 0 in every state except IDLE. `s_tdata` and `s_tlast` are ignored outside a transfer.
- `s_tvalid` may drop without a transfer; the block stays in IDLE.
- Counters:
  - Cycle counter: $clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT-1. Its terminal count ends the bit period.
  - Bit counter: wide enough for max(DATA_WIDTH, STOP_BITS, GAP_BITS).
  - Both counters clear on every state change.
- Illegal `PARITY` or `STOP_BITS` values are caught by an elaboration-time assertion.

## Timing

- Reset values: `tx`=1, `s_tready`=0, `busy`=0, state IDLE, counters 0. `s_tready` rises on the first cycle after `rst` deasserts.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency: for a transfer at edge N, `tx` goes low on the cycle following edge N. `s_tready` and `busy` change on the same edge.
- Frame length F = (1 + DATA_WIDTH + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- `s_tready` reasserts on the cycle after the final stop period. That cycle plus any further idle cycles are mark.
- Back-to-back throughput is one byte per F+1 cycles. With the gap active, add GAP_BITS × CLKS_PER_BIT cycles.
- Reset mid-frame: on the cycle after `rst` is sampled high, `tx`=1 and the FSM is in IDLE. The in-flight byte is dropped and no partial stop or gap is sent.
- `rst` held high with `s_tvalid`=1: no transfer occurs.

## Structure

- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t`;
  - parity localparams `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
  - The future receiver also uses this package.
- One natural sub-module, `uart_bit_timer`:
  - counts CLKS_PER_BIT and emits a one-cycle `bit_done`;
  - has a synchronous `clear` input, driven by the FSM on state change.
- The FSM, shift register and parity logic stay in `uart_tx_axis`.

## Test plan

- Basic frame: CLKS_PER_BIT=4, no parity, 1 stop, send 0xA5 → `tx` bit periods are 0,1,0,1,0,0,1,0,1,1. Each period is exactly 4 cycles, `tx` falls the cycle after the handshake, and `s_tready` is low for 40 cycles.
- Parity: 0xA5 with PARITY=1 → parity bit 0. With PARITY=2 → parity bit 1. Total frame is 44 cycles.
- Back-to-back with random `s_tvalid` stalls: 3-byte frame 0x00, 0xFF, 0x3C with tlast on 0x3C, STOP_BITS=2, GAP_BITS=3.
  - A UART-decoding monitor recovers all three bytes in order.
  - The handshake spacing is ≥ F+1.
  - 12 extra mark cycles follow 0x3C before `s_tready` rises.
- Reset mid-DATA: assert `rst` during bit 3 → `tx`=1 and `busy`=0 next cycle. The next byte sent (0x5A) decodes correctly.
- Reset state: assert `rst` for 3 cycles with `s_tvalid`=1 → no transfer, `tx`=1, `s_tready`=0, then `s_tready`=1 on the first cycle after release.
